// File: rtl/agc_pkg.sv
// Shared types and gain-code constants for the adaptive gain controller.
// Gain code: [7:4] multiplier code (factor code+1), [3:0] shift code.
package agc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMeasure,
    StDecide,
    StUpdate,
    StSettle
  } agc_state_e;

  localparam logic [3:0] SHIFT_NONE = 4'd8;
  localparam logic [3:0] SHIFT_MIN  = 4'd7;
  localparam logic [3:0] SHIFT_MAX  = 4'd15;

  localparam logic [3:0] MULT_MIN        = 4'd0;
  localparam logic [3:0] MULT_MAX        = 4'd15;
  localparam logic [3:0] MULT_HIGH_FLOOR = 4'd7;
  localparam logic [3:0] MULT_AFTER_UP   = 4'd8;
  localparam logic [3:0] MULT_AFTER_DOWN = 4'd14;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Shift code 0 is meaningless to the scaler; treat it as "no shift".
  function automatic logic [7:0] normalize_gain(input logic [7:0] gain);
    return (gain[3:0] == 4'd0) ? {gain[7:4], SHIFT_NONE} : gain;
  endfunction

endpackage

// File: rtl/agc_gain_ladder.sv
// One step up or down the gain ladder; purely combinational.
// Ladder order by shift: 7,6,...,1,8,9,...,15 (weakest to strongest).
module agc_gain_ladder
  import agc_pkg::*;
(
  input  logic [7:0] code,
  input  logic       direction,
  output logic [7:0] next_code,
  output logic       saturated
);

  logic [3:0] mult;
  logic [3:0] shift;
  logic [3:0] shift_rise;
  logic [3:0] shift_fall;
  logic       can_rise;
  logic       can_fall;

  assign mult  = code[7:4];
  assign shift = code[3:0];

  always_comb begin
    shift_rise = shift;
    can_rise   = 1'b1;
    if (shift == 4'd1) begin
      shift_rise = SHIFT_NONE;
    end else if (shift >= 4'd2 && shift <= SHIFT_MIN) begin
      shift_rise = shift - 4'd1;
    end else if (shift >= SHIFT_NONE && shift < SHIFT_MAX) begin
      shift_rise = shift + 4'd1;
    end else begin
      can_rise = 1'b0;
    end

    // Unity shift is never left on the way down; the multiplier trims instead.
    shift_fall = shift;
    can_fall   = 1'b1;
    if (shift > SHIFT_NONE) begin
      shift_fall = shift - 4'd1;
    end else if (shift >= 4'd1 && shift < SHIFT_MIN) begin
      shift_fall = shift + 4'd1;
    end else begin
      can_fall = 1'b0;
    end
  end

  always_comb begin
    next_code = code;
    saturated = 1'b0;
    if (direction == DIR_UP) begin
      if (mult < MULT_MAX) begin
        next_code = {mult + 4'd1, shift};
      end else if (can_rise) begin
        next_code = {MULT_AFTER_UP, shift_rise};
      end else begin
        saturated = 1'b1;
      end
    end else begin
      if (mult > MULT_HIGH_FLOOR) begin
        next_code = {mult - 4'd1, shift};
      end else if (can_fall) begin
        next_code = {MULT_AFTER_DOWN, shift_fall};
      end else if (mult > MULT_MIN) begin
        next_code = {mult - 4'd1, shift};
      end else begin
        saturated = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adaptive_gain_controller.sv
// Closed-loop AGC: measures window peaks of the scaled signal and steps the
// scaler gain code up or down, with clip detection and post-change settling.
module adaptive_gain_controller
  import agc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           WINDOW_LOG2    = 10,
  parameter logic [DATA_WIDTH-2:0] LOW_THRESH     = (DATA_WIDTH-1)'(1) << (DATA_WIDTH-4),
  parameter logic [DATA_WIDTH-2:0] HIGH_THRESH    = (DATA_WIDTH-1)'(1) << (DATA_WIDTH-3),
  parameter logic [DATA_WIDTH-2:0] CLIP_THRESH    = {(DATA_WIDTH-1){1'b1}}
                                                    - ((DATA_WIDTH-1)'(1) << (DATA_WIDTH-6))
                                                    + (DATA_WIDTH-1)'(1),
  parameter int unsigned           SETTLE_SAMPLES = 16,
  parameter logic [7:0]            INIT_GAIN      = 8'h08
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  agc_enable,
  input  logic [7:0]            manual_gain,
  output logic [7:0]            gain_control,
  output logic                  gain_update,
  output logic [DATA_WIDTH-2:0] peak_level,
  output logic [15:0]           clip_count
);

  localparam int unsigned SettleW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [SettleW-1:0] SettleLast =
    SettleW'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
  localparam logic [SettleW-1:0]     SettleOne = 1;
  localparam logic [WINDOW_LOG2-1:0] WinOne    = 1;
  localparam logic [DATA_WIDTH-1:0]  DataOne   = 1;

  agc_state_e state_q, state_d;
  logic [7:0]             gain_q, gain_d;
  logic                   gain_update_q, gain_update_d;
  logic [DATA_WIDTH-2:0]  peak_q, peak_d;
  logic [DATA_WIDTH-2:0]  peak_level_q, peak_level_d;
  logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [SettleW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [15:0]            clip_cnt_q, clip_cnt_d;
  logic                   dir_q, dir_d;

  logic [DATA_WIDTH-1:0] abs_full;
  logic [DATA_WIDTH-2:0] magnitude;
  logic [DATA_WIDTH-2:0] peak_max;
  logic                  clip_hit;
  logic [7:0]            ladder_code;
  logic                  ladder_sat;

  // Most negative input has no positive twin; clamp it to full scale.
  assign abs_full  = sample_in[DATA_WIDTH-1] ? (~sample_in + DataOne) : sample_in;
  assign magnitude = abs_full[DATA_WIDTH-1] ? {(DATA_WIDTH-1){1'b1}}
                                            : abs_full[DATA_WIDTH-2:0];
  assign peak_max  = (magnitude > peak_q) ? magnitude : peak_q;
  assign clip_hit  = sample_valid_in && (magnitude >= CLIP_THRESH);

  agc_gain_ladder u_ladder (
    .code      (gain_q),
    .direction (dir_q),
    .next_code (ladder_code),
    .saturated (ladder_sat)
  );

  always_comb begin
    state_d       = state_q;
    gain_d        = gain_q;
    gain_update_d = 1'b0;
    peak_d        = peak_q;
    peak_level_d  = peak_level_q;
    win_cnt_d     = win_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    clip_cnt_d    = clip_cnt_q;
    dir_d         = dir_q;

    if (clip_hit && state_q != StIdle && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end

    if (!agc_enable) begin
      if (state_q == StIdle) begin
        gain_d = manual_gain;
      end
      state_d      = StIdle;
      peak_d       = '0;
      win_cnt_d    = '0;
      settle_cnt_d = '0;
      dir_d        = DIR_UP;
    end else begin
      unique case (state_q)
        StIdle: begin
          gain_d       = normalize_gain(manual_gain);
          peak_d       = '0;
          win_cnt_d    = '0;
          settle_cnt_d = '0;
          state_d      = StMeasure;
        end
        StMeasure: begin
          if (clip_hit) begin
            dir_d     = DIR_DOWN;
            peak_d    = '0;
            win_cnt_d = '0;
            state_d   = StUpdate;
          end else if (sample_valid_in) begin
            peak_d    = peak_max;
            win_cnt_d = win_cnt_q + WinOne;
            if (&win_cnt_q) begin
              peak_level_d = peak_max;
              state_d      = StDecide;
            end
          end
        end
        StDecide: begin
          peak_d    = '0;
          win_cnt_d = '0;
          if (peak_level_q > HIGH_THRESH) begin
            dir_d   = DIR_DOWN;
            state_d = StUpdate;
          end else if (peak_level_q < LOW_THRESH) begin
            dir_d   = DIR_UP;
            state_d = StUpdate;
          end else begin
            state_d = StMeasure;
          end
        end
        StUpdate: begin
          if (!ladder_sat) begin
            gain_d        = ladder_code;
            gain_update_d = 1'b1;
          end
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
        StSettle: begin
          if (SETTLE_SAMPLES == 0) begin
            state_d = StMeasure;
          end else if (sample_valid_in) begin
            if (settle_cnt_q == SettleLast) begin
              settle_cnt_d = '0;
              peak_d       = '0;
              win_cnt_d    = '0;
              state_d      = StMeasure;
            end else begin
              settle_cnt_d = settle_cnt_q + SettleOne;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      gain_q        <= INIT_GAIN;
      gain_update_q <= 1'b0;
      peak_q        <= '0;
      peak_level_q  <= '0;
      win_cnt_q     <= '0;
      settle_cnt_q  <= '0;
      clip_cnt_q    <= '0;
      dir_q         <= DIR_UP;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      peak_q        <= peak_d;
      peak_level_q  <= peak_level_d;
      win_cnt_q     <= win_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      clip_cnt_q    <= clip_cnt_d;
      dir_q         <= dir_d;
    end
  end

  assign gain_control = gain_q;
  assign gain_update  = gain_update_q;
  assign peak_level   = peak_level_q;
  assign clip_count   = clip_cnt_q;

endmodule
